// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : PLL-domain reset sequencer. It waits for lock to be stable,
//               holds reset, then releases sys_rst_n. It also counts lock losses.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 1024,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       sys_rst_n,
    output logic [2:0] state,
    output logic       loss_pulse,
    output logic [7:0] loss_cnt
);

    localparam int C_CNT_MAX = (LOCK_STABLE > HOLD_CYCLES) ? LOCK_STABLE : HOLD_CYCLES;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam logic [C_CNT_W-1:0] C_STABLE_LAST = C_CNT_W'(LOCK_STABLE - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST   = C_CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    logic [1:0]             r_rst_sync;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    state_t                 r_state;
    logic [C_CNT_W-1:0]     r_cnt;
    logic                   r_sys_rst_n;
    logic                   r_loss_pulse;
    logic [7:0]             r_loss_cnt;
    logic                   w_locked_s;

    assign w_locked_s = r_lock_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_rst_sync  <= {r_rst_sync[0], 1'b1};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
        end
    end

    // sys_rst_n is driven high exactly on the transitions whose next state is RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RESET;
            r_cnt        <= '0;
            r_sys_rst_n  <= 1'b0;
            r_loss_pulse <= 1'b0;
            r_loss_cnt   <= 8'd0;
        end else begin
            r_sys_rst_n  <= 1'b0;
            r_loss_pulse <= 1'b0;
            case (r_state)
                ST_RESET: begin
                    if (r_rst_sync[1]) begin
                        r_state <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (r_cnt == C_STABLE_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!w_locked_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (r_cnt == C_HOLD_LAST) begin
                        r_state     <= ST_RUN;
                        r_sys_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        r_state      <= ST_WAIT_LOCK;
                        r_loss_pulse <= 1'b1;
                        if (r_loss_cnt != 8'hFF) begin
                            r_loss_cnt <= r_loss_cnt + 8'd1;
                        end
                    end else begin
                        r_sys_rst_n <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    assign sys_rst_n  = r_sys_rst_n;
    assign state      = r_state;
    assign loss_pulse = r_loss_pulse;
    assign loss_cnt   = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_seq
// Description : Vector-table bench for pll_reset_seq with a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       sys_rst_n;
    logic [2:0] state;
    logic       loss_pulse;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int pulse_seen = 0;
    int pulse_base;

    typedef struct {
        logic       lk;
        logic [2:0] st;
        logic       srn;
        logic       pl;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    pll_reset_seq #(
        .SYNC_STAGES(2),
        .LOCK_STABLE(8),
        .HOLD_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .sys_rst_n (sys_rst_n),
        .state     (state),
        .loss_pulse(loss_pulse),
        .loss_cnt  (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (loss_pulse === 1'b1) pulse_seen++;
    end

    function automatic void add(input logic lk, input logic [2:0] st, input logic srn,
                                input logic pl, input logic [7:0] cnt);
        vec_t v;
        v.lk = lk; v.st = st; v.srn = srn; v.pl = pl; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    // Reset released just before the first vector's edge: RESET, RESET, then WAIT_LOCK.
    function automatic void add_reset();
        add(0, 3'd0, 0, 0, 8'd0);
        add(0, 3'd0, 0, 0, 8'd0);
        add(0, 3'd1, 0, 0, 8'd0);
        add(0, 3'd1, 0, 0, 8'd0);
        add(0, 3'd1, 0, 0, 8'd0);
    endfunction

    // locked first sampled at the first entry: STABLE at t+2, HOLD at t+10, RUN at t+14.
    function automatic void add_lock(input logic [7:0] c, input int hold_len, input bit to_run);
        for (int i = 0; i < 2; i++) add(1, 3'd1, 0, 0, c);
        for (int i = 0; i < 8; i++) add(1, 3'd2, 0, 0, c);
        for (int i = 0; i < hold_len; i++) add(1, 3'd3, 0, 0, c);
        if (to_run) for (int i = 0; i < 2; i++) add(1, 3'd4, 1, 0, c);
    endfunction

    function automatic void add_loss(input logic [7:0] c0, input logic [7:0] c1);
        add(0, 3'd4, 1, 0, c0);
        add(0, 3'd4, 1, 0, c0);
        add(0, 3'd1, 0, 1, c1);
        add(0, 3'd1, 0, 0, c1);
        add(0, 3'd1, 0, 0, c1);
    endfunction

    // Five STABLE cycles, then three low samples drop back to WAIT_LOCK.
    function automatic void add_glitch(input logic [7:0] c);
        for (int i = 0; i < 2; i++) add(1, 3'd1, 0, 0, c);
        for (int i = 0; i < 3; i++) add(1, 3'd2, 0, 0, c);
        add(0, 3'd2, 0, 0, c);
        add(0, 3'd2, 0, 0, c);
        add(0, 3'd1, 0, 0, c);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_next(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard (vec %0d): got empty queue expected entry", idx);
            return;
        end
        e = exp_q.pop_front();
        chk("state", idx, {5'd0, state}, {5'd0, e.st});
        chk("sys_rst_n", idx, {7'd0, sys_rst_n}, {7'd0, e.srn});
        chk("loss_pulse", idx, {7'd0, loss_pulse}, {7'd0, e.pl});
        chk("loss_cnt", idx, loss_cnt, e.cnt);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            locked = vecs[i].lk;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            check_next(i);
        end
        vecs.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;

        add_reset();
        add_lock(8'd0, 4, 1);
        add_loss(8'd0, 8'd1);
        add_glitch(8'd1);
        add_lock(8'd1, 4, 1);
        add_loss(8'd1, 8'd2);
        add_lock(8'd2, 4, 1);
        add_loss(8'd2, 8'd3);
        add_lock(8'd3, 2, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst state", -1, {5'd0, state}, 8'd0);
        chk("rst sys_rst_n", -1, {7'd0, sys_rst_n}, 8'd0);
        chk("rst loss_pulse", -1, {7'd0, loss_pulse}, 8'd0);
        chk("rst loss_cnt", -1, loss_cnt, 8'd0);
        rst_n = 1'b1;
        run_vecs();

        // Now mid-HOLD with loss_cnt=3: reset must clear outputs without a clock edge.
        #2;
        rst_n  = 1'b0;
        locked = 1'b0;
        #1;
        chk("midhold state", -1, {5'd0, state}, 8'd0);
        chk("midhold sys_rst_n", -1, {7'd0, sys_rst_n}, 8'd0);
        chk("midhold loss_cnt", -1, loss_cnt, 8'd0);
        chk("midhold loss_pulse", -1, {7'd0, loss_pulse}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("held state", -1, {5'd0, state}, 8'd0);
        rst_n = 1'b1;

        add_reset();
        for (int i = 0; i < 257; i++) begin
            add_lock((i < 255) ? 8'(i) : 8'd255, 4, 1);
            add_loss((i < 255) ? 8'(i) : 8'd255, (i < 254) ? 8'(i + 1) : 8'd255);
        end
        pulse_base = pulse_seen;
        run_vecs();
        #10;
        chk("sat loss_cnt", -1, loss_cnt, 8'd255);
        checks++;
        if (pulse_seen - pulse_base != 257) begin
            errors++;
            $display("FAIL sat pulses: got %0d expected 257", pulse_seen - pulse_base);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
